// File: rtl/tiny16_pkg.sv
// tiny16_pkg: shared widths and arbiter state encoding
package tiny16_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int IDX_W  = 3;
   typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just after last
module rr_pick import tiny16_pkg::*; #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] win,
   output logic             valid
);
   // walk from furthest to nearest so the nearest requester after last wins
   always_comb begin
      win   = '0;
      valid = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NREQ]) begin
            win   = IDX_W'((int'(last) + k) % NREQ);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one synchronous memory port with lock and hold limit
module mem_arbiter #(
   parameter int NREQ     = 2,
   parameter int ADDR_W   = tiny16_pkg::ADDR_W,
   parameter int DATA_W   = tiny16_pkg::DATA_W,
   parameter int MAX_HOLD = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        lock,
   input  logic [NREQ-1:0]        we,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        wait_o,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [2:0]             owner,
   output logic                   busy
);
   import tiny16_pkg::*;

   arb_state_e        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d, rv_q, rv_d, others;
   logic [2:0]        owner_q, owner_d, last_q, last_d, win;
   logic [7:0]        hold_q, hold_d;
   logic              win_v, own_req, own_lock, own_we, beat, rel;
   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_wdata;

   // requests from everyone except the current owner compete for the next grant
   assign others = req & ~gnt_q;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (others),
      .last (last_q),
      .win  (win),
      .valid(win_v)
   );

   // select the owner's address and write data via AND-OR over the one-hot grant
   always_comb begin
      own_addr  = '0;
      own_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         own_addr  = own_addr  | (addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{gnt_q[i]}});
         own_wdata = own_wdata | (wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}});
      end
   end

   assign own_req   = |(req & gnt_q);
   assign own_lock  = |(lock & gnt_q);
   assign own_we    = |(we & gnt_q);
   assign beat      = own_req;
   assign rel       = ~own_req | ((hold_q == 8'(MAX_HOLD)) & ~own_lock);
   assign mem_en    = beat;
   assign mem_we    = beat & own_we;
   assign mem_addr  = beat ? own_addr : '0;
   assign mem_wdata = beat ? own_wdata : '0;
   assign wait_o    = others;
   assign gnt       = gnt_q;
   assign rvalid    = rv_q;
   assign rdata     = mem_rdata;
   assign owner     = owner_q;
   assign busy      = (state_q == ARB_OWNED);

   // next grant: arbitrate when idle or on release, otherwise advance the hold counter
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      rv_d    = (beat & ~own_we) ? gnt_q : '0;
      if (state_q == ARB_IDLE || rel) begin
         if (win_v) begin
            state_d = ARB_OWNED;
            gnt_d   = NREQ'(1) << win;
            owner_d = win;
            last_d  = win;
            hold_d  = '0;
         end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            owner_d = '0;
         end
      end else if (|others && hold_q != 8'(MAX_HOLD)) begin
         hold_d = hold_q + 8'd1;
      end
   end

   // state registers; reset drops any pending read response
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         last_q  <= 3'(NREQ - 1);
         hold_q  <= '0;
         rv_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         rv_q    <= rv_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, reads, writes, fairness, lock and handoff
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, lock, we, gnt, wait_o, rvalid;
   logic [31:0] addr, wdata;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_en, mem_we, busy;
   logic [2:0]  owner;
   logic [15:0] mem [256];
   logic [1:0]  cur, nxt;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cnt;

   mem_arbiter #(.NREQ(2), .ADDR_W(16), .DATA_W(16), .MAX_HOLD(8)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .wait_o(wait_o), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   // synchronous memory model: one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         else mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[8'h10] = 16'hBEEF;
      mem[8'h20] = 16'h1234;
      mem[8'h30] = 16'hCAFE;
      mem_rdata = '0;
      rst = 1'b0; req = 2'b11; lock = '0; we = '0; addr = '0; wdata = '0;
      // reset with both masters requesting
      step(); step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_mem_en", 32'(mem_en), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b1;
      step();
      check("first_gnt", 32'(gnt), 32'h1);
      check("first_owner", 32'(owner), 32'h0);
      check("first_busy", 32'(busy), 32'h1);
      check("first_wait", 32'(wait_o), 32'h2);
      // master 0 read
      addr = {16'h0000, 16'h0010};
      #1;
      check("rd_mem_en", 32'(mem_en), 32'h1);
      check("rd_mem_addr", 32'(mem_addr), 32'h0010);
      check("rd_mem_we", 32'(mem_we), 32'h0);
      step();
      check("rd_rvalid", 32'(rvalid), 32'h1);
      check("rd_rdata", 32'(rdata), 32'hBEEF);
      // master 0 write
      we = 2'b01; addr = {16'h0000, 16'h0040}; wdata = {16'h0000, 16'h5555};
      #1;
      check("wr_mem_we", 32'(mem_we), 32'h1);
      check("wr_mem_addr", 32'(mem_addr), 32'h0040);
      check("wr_mem_wdata", 32'(mem_wdata), 32'h5555);
      step();
      check("wr_rvalid", 32'(rvalid), 32'h0);
      check("wr_mem", 32'(mem[8'h40]), 32'h5555);
      we = '0;
      // fairness: four 9-beat tenures alternating with no bubble
      rst = 1'b0; step(); rst = 1'b1; step();
      check("fair_gnt0", 32'(gnt), 32'h1);
      cur = 2'b01;
      for (int t = 0; t < 4; t++) begin
         nxt = ~cur;
         cnt = 0;
         do begin
            step();
            cnt++;
         end while (gnt == cur && cnt < 40);
         check("tenure_len", cnt, 9);
         check("tenure_next", 32'(gnt), 32'(nxt));
         cur = nxt;
      end
      // lock: master 1 holds past the limit
      req = 2'b10; lock = 2'b10;
      rst = 1'b0; step(); rst = 1'b1; step();
      check("lock_gnt", 32'(gnt), 32'h2);
      addr = {16'h0020, 16'h0040};
      req = 2'b11;
      repeat (20) step();
      check("lock_hold", 32'(gnt), 32'h2);
      check("lock_wait", 32'(wait_o), 32'h1);
      check("lock_rvalid", 32'(rvalid), 32'h2);
      check("lock_rdata", 32'(rdata), 32'h1234);
      // lock drops: the final read beat coincides with the handoff
      addr = {16'h0030, 16'h0040};
      lock = '0;
      step();
      check("handoff_gnt", 32'(gnt), 32'h1);
      check("handoff_rvalid", 32'(rvalid), 32'h2);
      check("handoff_rdata", 32'(rdata), 32'hCAFE);
      // master 0 drops, master 1 takes over, then reset mid-read
      req = 2'b10;
      step();
      check("drop_gnt", 32'(gnt), 32'h2);
      rst = 1'b0;
      step();
      check("midrst_gnt", 32'(gnt), 32'h0);
      check("midrst_rvalid", 32'(rvalid), 32'h0);
      check("midrst_owner", 32'(owner), 32'h0);
      rst = 1'b1; req = 2'b11;
      step();
      check("restart_gnt", 32'(gnt), 32'h1);
      // sole owner releases with nobody waiting
      req = 2'b01;
      step();
      check("solo_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      step();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_mem_en", 32'(mem_en), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
